vector_point_pacer: RTL and testbench

Receiving end of the line-drawer pixel stream. Accepts `wr`/`xin`/`yin` points at up to one per clock, buffers them in a FIFO, and presents each point to the X/Y DAC registers for a fixed dwell time. While the FIFO is empty, the beam is blanked. The block sits between the line drawer and the DAC pins of the vector display, and absorbs bursty line output against the slower, constant beam slew rate.

---
 rtl/vector_point_pacer.sv | 149 ++++++++++++++
 tb/tb_vector_point_pacer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_point_pacer.sv
// vector_point_pacer: point FIFO feeding the X/Y DAC registers of a vector
// display. Each queued point is held on the DAC for DWELL cycles, and the
// beam is blanked whenever nothing is queued.
// Optional build macro VECTOR_PACER_DEDUP_EN drops a write that repeats the
// last accepted point before it reaches the FIFO.
module vector_point_pacer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DWELL      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [7:0]            xin,
    input  logic [7:0]            yin,
    input  logic                  clr_ovf,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            dac_x,
    output logic [7:0]            dac_y,
    output logic                  dac_load,
    output logic                  beam_on
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [7:0]        RELOAD    = 8'(DWELL - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DWELL = 1'b1;

    logic [15:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_ovf;
    logic [0:0]            r_state;
    logic [7:0]            r_cnt;
    logic [7:0]            r_dac_x;
    logic [7:0]            r_dac_y;
    logic                  r_load;
    logic                  r_beam;

    logic [15:0]           w_pt;
    logic [15:0]           w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_dup;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;

    assign w_pt    = {xin, yin};
    assign w_head  = r_mem[r_rptr];
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);

`ifdef VECTOR_PACER_DEDUP_EN
    logic [15:0] r_last;
    logic        r_last_vld;

    assign w_dup = r_last_vld && (w_pt == r_last);

    // Remember the most recently accepted point for duplicate suppression
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_push) begin
            r_last     <= w_pt;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // Fullness is judged on the registered level, so a same-cycle pop never
    // rescues a write into a full FIFO
    assign w_push = wr && !w_full && !w_dup;
    assign w_drop = wr &&  w_full && !w_dup;
    assign w_pop  = !w_empty && ((r_state == S_IDLE) || (r_cnt == '0));

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_pt;
        end
    end

    // FIFO pointers, level and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    // Pacer: load a point, hold it DWELL cycles, chain or blank when done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dac_x <= '0;
            r_dac_y <= '0;
            r_load  <= 1'b0;
            r_beam  <= 1'b0;
        end else begin
            r_load <= w_pop;
            if (w_pop) begin
                r_dac_x <= w_head[15:8];
                r_dac_y <= w_head[7:0];
                r_beam  <= 1'b1;
                r_cnt   <= RELOAD;
                r_state <= S_DWELL;
            end else if (r_state == S_DWELL) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_state <= S_IDLE;
                    r_beam  <= 1'b0;
                end
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_ovf;
    assign dac_x    = r_dac_x;
    assign dac_y    = r_dac_y;
    assign dac_load = r_load;
    assign beam_on  = r_beam;

endmodule

// File: tb/tb_vector_point_pacer.sv
// Testbench for vector_point_pacer: directed and random point streams are
// fed to the DUT while a queue-based reference model predicts the drained
// point sequence (scoreboard) and the per-cycle flags.
module tb_vector_point_pacer;

    localparam int TB_DL2   = 2;
    localparam int TB_DWELL = 3;
    localparam int TB_DEPTH = 1 << TB_DL2;

    logic              clk;
    logic              rst;
    logic              wr;
    logic [7:0]        xin;
    logic [7:0]        yin;
    logic              clr_ovf;
    logic              full;
    logic              empty;
    logic [TB_DL2:0]   level;
    logic              overflow;
    logic [7:0]        dac_x;
    logic [7:0]        dac_y;
    logic              dac_load;
    logic              beam_on;

    vector_point_pacer #(
        .DEPTH_LOG2 (TB_DL2),
        .DWELL      (TB_DWELL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .xin      (xin),
        .yin      (yin),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .dac_x    (dac_x),
        .dac_y    (dac_y),
        .dac_load (dac_load),
        .beam_on  (beam_on)
    );

    // Free-running clock, first rising edge at 5
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state: queued points, remaining hold cycles of the
    // current point (0 = blanked), and the expected DAC contents
    logic [15:0] mq[$];
    logic [15:0] exp_q[$];
    int          m_timer = 0;
    bit          m_ovf   = 1'b0;
    bit          m_load  = 1'b0;
    logic [15:0] m_dac   = '0;
    bit          m_lv    = 1'b0;
    logic [15:0] m_last  = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advance one clock using the inputs presented at this edge
    always @(posedge clk) begin
        bit          mfull;
        bit          mempty;
        bit          dup;
        bit          push;
        bit          drop;
        bit          pop;
        logic [15:0] p;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_timer = 0;
            m_ovf   = 1'b0;
            m_load  = 1'b0;
            m_dac   = '0;
            m_lv    = 1'b0;
        end else begin
            mfull  = (mq.size() == TB_DEPTH);
            mempty = (mq.size() == 0);
            p      = {xin, yin};
`ifdef VECTOR_PACER_DEDUP_EN
            dup = wr && m_lv && (p == m_last);
`else
            dup = 1'b0;
`endif
            push = wr && !mfull && !dup;
            drop = wr && mfull && !dup;
            pop  = !mempty && (m_timer <= 1);
            m_load = pop;
            if (pop) begin
                m_dac   = mq.pop_front();
                exp_q.push_back(m_dac);
                m_timer = TB_DWELL;
            end else if (m_timer > 0) begin
                m_timer--;
            end
            if (push) begin
                mq.push_back(p);
                m_last = p;
                m_lv   = 1'b1;
            end
            if (drop)         m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // Monitor: compare flags every cycle and pop the scoreboard on each load
    always @(negedge clk) begin
        logic [15:0] e;
        if (chk_en) begin
            check("level",    int'(level),    mq.size());
            check("full",     int'(full),     int'(mq.size() == TB_DEPTH));
            check("empty",    int'(empty),    int'(mq.size() == 0));
            check("overflow", int'(overflow), int'(m_ovf));
            check("beam_on",  int'(beam_on),  int'(m_timer > 0));
            check("dac_load", int'(dac_load), int'(m_load));
            check("dac_hold", int'({dac_x, dac_y}), int'(m_dac));
            if (dac_load) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dac_point: got %0d,%0d expected no load", dac_x, dac_y);
                end else begin
                    e = exp_q.pop_front();
                    check("dac_x_point", int'(dac_x), int'(e[15:8]));
                    check("dac_y_point", int'(dac_y), int'(e[7:0]));
                end
            end
        end
    end

    task automatic wr_pt(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        wr  = 1'b1;
        xin = x;
        yin = y;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wr      = 1'b0;
            clr_ovf = 1'b0;
            rst     = 1'b0;
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr      = 1'b0;
        xin     = '0;
        yin     = '0;
        clr_ovf = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Single point
        wr_pt(8'd10, 8'd20);
        idle(10);

        // Burst of six consecutive points
        for (int i = 0; i < 6; i++) wr_pt(8'(i + 1), 8'(100 + i));
        idle(25);

        // Overflow, then a clear that coincides with a dropped write
        for (int i = 0; i < 8; i++) wr_pt(8'(200 + i), 8'(i));
        @(negedge clk);
        wr = 1'b1; xin = 8'd77; yin = 8'd77; clr_ovf = 1'b1;
        idle(3);
        @(negedge clk);
        clr_ovf = 1'b1;
        idle(20);

        // Repeated endpoints
        wr_pt(8'd5, 8'd5);
        wr_pt(8'd5, 8'd5);
        wr_pt(8'd6, 8'd5);
        wr_pt(8'd6, 8'd5);
        idle(20);

        // Reset in the middle of a dwell with points queued
        for (int i = 0; i < 6; i++) wr_pt(8'(30 + i), 8'(40 + i));
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        idle(6);

        // Random traffic with small coordinate range to provoke duplicates
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            wr      = ($urandom_range(0, 3) != 0);
            xin     = 8'($urandom_range(0, 3));
            yin     = 8'($urandom_range(0, 3)) ^ 8'($urandom_range(0, 1) << 7);
            clr_ovf = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 199) == 0);
        end

        // Full-range coordinates
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            wr      = ($urandom_range(0, 2) == 0);
            xin     = 8'($urandom);
            yin     = 8'($urandom);
            clr_ovf = 1'b0;
            rst     = 1'b0;
        end
        idle(40);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
